// File: rtl/user_wb_gpio_port_if.sv
// Wishbone slave bus bundle for the user GPIO port (cyc/stb/we/sel/adr/dat in, ack/dat out).
// Latency: none, wires only.
// Backpressure: none here; the slave paces transfers with wbs_ack_o.
// Ports: slave modport is the block side and master modport is the SoC/bench side.
interface user_wb_gpio_port_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_wb_gpio_port.sv
// Wishbone register block that drives the user pad levels and enables, samples the pad inputs, and holds a counter and an ID word.
// Latency: ack and the register update or read capture happen on the edge after the request, and ack is a 1-cycle pulse.
// Backpressure: back-to-back requests are acknowledged every other cycle, because a request is only seen while ack is low.
// Ports: wb_clk_i/resetb (async, active low); wb = Wishbone slave; io_in = pad inputs; io_out = pad levels; io_oeb = active-low enables.
module user_wb_gpio_port #(
  parameter int          IO_WIDTH = 38,
  parameter logic [31:0] ID_VALUE = 32'hAB60_0012
) (
  input  logic                wb_clk_i,
  input  logic                resetb,
  user_wb_gpio_port_if.slave  wb,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic [IO_WIDTH-1:0] io_oeb
);
  localparam int HI_W = IO_WIDTH - 32;

  // Word index is adr[7:2].
  localparam logic [5:0] A_OUT_LO = 6'h00;
  localparam logic [5:0] A_OUT_HI = 6'h01;
  localparam logic [5:0] A_OEB_LO = 6'h02;
  localparam logic [5:0] A_OEB_HI = 6'h03;
  localparam logic [5:0] A_IN_LO  = 6'h04;
  localparam logic [5:0] A_IN_HI  = 6'h05;
  localparam logic [5:0] A_COUNT  = 6'h06;
  localparam logic [5:0] A_CTRL   = 6'h07;
  localparam logic [5:0] A_ID     = 6'h08;

  logic                req, wr, rd;
  logic [5:0]          reg_idx;
  logic [31:0]         rd_val;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic [IO_WIDTH-1:0] out_q, out_d;
  logic [IO_WIDTH-1:0] oeb_q, oeb_d;
  logic [IO_WIDTH-1:0] sync1_q, sync1_d;
  logic [IO_WIDTH-1:0] sync2_q, sync2_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                ctrl_q, ctrl_d;

  // Address bits outside [7:2] are deliberately ignored.
  logic unused_adr;
  assign unused_adr = ^{wb.wbs_adr_i[31:8], wb.wbs_adr_i[1:0]};

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    lane_merge = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) lane_merge[8*i +: 8] = new_v[8*i +: 8];
    end
  endfunction

  always_comb begin
    req     = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
    wr      = req & wb.wbs_we_i;
    rd      = req & ~wb.wbs_we_i;
    reg_idx = wb.wbs_adr_i[7:2];

    ack_d   = req;
    out_d   = out_q;
    oeb_d   = oeb_q;
    ctrl_d  = ctrl_q;
    sync1_d = io_in;
    sync2_d = sync1_q;
    // The increment is the base value, so a partial COUNT write leaves the
    // unwritten lanes counting.
    cnt_d   = ctrl_q ? cnt_q + 32'd1 : cnt_q;

    if (wr) begin
      case (reg_idx)
        A_OUT_LO: out_d[31:0] = lane_merge(out_q[31:0], wb.wbs_dat_i, wb.wbs_sel_i);
        A_OUT_HI: if (wb.wbs_sel_i[0]) out_d[IO_WIDTH-1:32] = wb.wbs_dat_i[HI_W-1:0];
        A_OEB_LO: oeb_d[31:0] = lane_merge(oeb_q[31:0], wb.wbs_dat_i, wb.wbs_sel_i);
        A_OEB_HI: if (wb.wbs_sel_i[0]) oeb_d[IO_WIDTH-1:32] = wb.wbs_dat_i[HI_W-1:0];
        A_COUNT:  cnt_d = lane_merge(cnt_d, wb.wbs_dat_i, wb.wbs_sel_i);
        A_CTRL:   if (wb.wbs_sel_i[0]) ctrl_d = wb.wbs_dat_i[0];
        default:  ;
      endcase
    end

    rd_val = '0;
    case (reg_idx)
      A_OUT_LO: rd_val = out_q[31:0];
      A_OUT_HI: rd_val = {{(32-HI_W){1'b0}}, out_q[IO_WIDTH-1:32]};
      A_OEB_LO: rd_val = oeb_q[31:0];
      A_OEB_HI: rd_val = {{(32-HI_W){1'b0}}, oeb_q[IO_WIDTH-1:32]};
      A_IN_LO:  rd_val = sync2_q[31:0];
      A_IN_HI:  rd_val = {{(32-HI_W){1'b0}}, sync2_q[IO_WIDTH-1:32]};
      A_COUNT:  rd_val = cnt_q;
      A_CTRL:   rd_val = {31'd0, ctrl_q};
      A_ID:     rd_val = ID_VALUE;
      default:  rd_val = '0;
    endcase

    // Read data is held until the next read, so writes leave it untouched.
    dat_d = rd ? rd_val : dat_q;
  end

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      out_q   <= '0;
      oeb_q   <= '1;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      ctrl_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign io_out       = out_q;
  assign io_oeb       = oeb_q;
endmodule

// File: tb/tb_user_wb_gpio_port.sv
// Scoreboard bench for user_wb_gpio_port: bus tasks queue the expected read data and a negedge monitor checks each ack.
// Latency: each task drives, waits for ack (expected 1 cycle), then idles one cycle.
// Backpressure: every wait for ack is bounded by a cycle budget.
module tb_user_wb_gpio_port;
  logic        clk;
  logic        resetb;
  logic [37:0] io_in;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  user_wb_gpio_port_if wb ();

  user_wb_gpio_port dut (
    .wb_clk_i (clk),
    .resetb   (resetb),
    .wb       (wb.slave),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  typedef struct packed {
    logic        rd;
    logic [7:0]  adr;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every ack consumes one scoreboard entry; reads compare data.
  always @(negedge clk) begin
    if (wb.wbs_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=ack required=no_ack");
      end else begin
        sb_t it;
        it = sb_q.pop_front();
        if (it.rd) begin
          checks++;
          if (wb.wbs_dat_o !== it.exp) begin
            failures++;
            $display("FAIL rd_0x%02h actual=%08h required=%08h", it.adr, wb.wbs_dat_o, it.exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [31:0] exp);
    int n;
    sb_q.push_back('{rd: !we, adr: adr, exp: exp});
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = {24'd0, adr};
    wb.wbs_dat_i = dat;
    wb.wbs_sel_i = sel;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (wb.wbs_ack_o !== 1'b1 && n < 8);
    if (wb.wbs_ack_o !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout adr=%02h actual=no_ack required=ack", adr);
    end else begin
      chk("ack_latency", 64'(n), 64'd1);
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_pulse", {63'd0, wb.wbs_ack_o}, 64'd0);
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus(1'b1, adr, dat, sel, 32'd0);
  endtask

  task automatic rd(input logic [7:0] adr, input logic [31:0] exp);
    bus(1'b0, adr, 32'd0, 4'h0, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb       = 1'b0;
    io_in        = '0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'd0;
    wb.wbs_dat_i = 32'd0;
    idle(3);
    chk("rst_ack",    {63'd0, wb.wbs_ack_o}, 64'd0);
    chk("rst_dat",    {32'd0, wb.wbs_dat_o}, 64'd0);
    chk("rst_io_out", {26'd0, io_out},       64'd0);
    chk("rst_io_oeb", {26'd0, io_oeb},       64'h3F_FFFF_FFFF);
    resetb = 1'b1;
    idle(1);

    // Reset values through the bus.
    rd(8'h20, 32'hAB60_0012);
    rd(8'h08, 32'hFFFF_FFFF);
    rd(8'h0C, 32'h0000_003F);
    rd(8'h00, 32'h0000_0000);
    rd(8'h1C, 32'h0000_0000);
    rd(8'h18, 32'h0000_0000);

    // Status word and result byte on the pads.
    wr(8'h08, 32'h0000_0000, 4'hF);
    wr(8'h00, 32'hAB60_1200, 4'hF);
    chk("io_out_status", {48'd0, io_out[31:16]}, 64'hAB60);
    chk("io_out_result", {56'd0, io_out[15:8]},  64'h12);
    chk("io_oeb_lo",     {32'd0, io_oeb[31:0]},  64'd0);
    chk("io_oeb_hi",     {58'd0, io_oeb[37:32]}, 64'h3F);
    rd(8'h00, 32'hAB60_1200);

    // Byte-lane writes.
    wr(8'h00, 32'h0000_0000, 4'hF);
    wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
    rd(8'h00, 32'h0000_FF00);
    wr(8'h04, 32'hFFFF_FFFF, 4'hF);
    rd(8'h04, 32'h0000_003F);
    chk("io_out_hi", {58'd0, io_out[37:32]}, 64'h3F);
    wr(8'h0C, 32'h0000_0015, 4'h1);
    chk("io_oeb_hi_wr", {58'd0, io_oeb[37:32]}, 64'h15);
    wr(8'h0C, 32'h0000_0000, 4'b1110);
    rd(8'h0C, 32'h0000_0015);

    // Counter: CTRL ack at edge C; increments start at C+1.
    wr(8'h18, 32'hFFFF_FFFE, 4'hF);
    wr(8'h1C, 32'h0000_0001, 4'hF);
    idle(4);
    rd(8'h18, 32'h0000_0003);   // ack at C+6: FFFFFFFE + 5, wrapped
    rd(8'h18, 32'h0000_0005);   // ack at C+8: FFFFFFFE + 7
    wr(8'h18, 32'h0000_0005, 4'hF);
    rd(8'h18, 32'h0000_0006);   // 5 + one elapsed increment
    wr(8'h18, 32'hAA00_0000, 4'b1000);  // low lanes take incremented 9
    rd(8'h18, 32'hAA00_000A);
    rd(8'h1C, 32'h0000_0001);

    // Input synchroniser and read-only registers.
    io_in = 38'h2A_5A5A_A5A5;
    idle(3);
    rd(8'h10, 32'h5A5A_A5A5);
    rd(8'h14, 32'h0000_002A);
    wr(8'h10, 32'hFFFF_FFFF, 4'hF);
    rd(8'h10, 32'h5A5A_A5A5);
    wr(8'h20, 32'h0000_0000, 4'hF);
    rd(8'h20, 32'hAB60_0012);

    // Unmapped offset.
    wr(8'h40, 32'hFFFF_FFFF, 4'hF);
    rd(8'h40, 32'h0000_0000);
    rd(8'h00, 32'h0000_FF00);
    rd(8'h04, 32'h0000_003F);

    // Reset during a pending request: no ack, no scoreboard entry.
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = 32'h20;
    #2;
    resetb = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ack",    {63'd0, wb.wbs_ack_o}, 64'd0);
    chk("midrst_io_out", {26'd0, io_out},       64'd0);
    chk("midrst_io_oeb", {26'd0, io_oeb},       64'h3F_FFFF_FFFF);
    chk("midrst_dat",    {32'd0, wb.wbs_dat_o}, 64'd0);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    idle(1);
    chk("midrst_ack2", {63'd0, wb.wbs_ack_o}, 64'd0);
    resetb = 1'b1;
    idle(1);
    rd(8'h08, 32'hFFFF_FFFF);
    rd(8'h0C, 32'h0000_003F);
    rd(8'h00, 32'h0000_0000);
    rd(8'h04, 32'h0000_0000);
    rd(8'h1C, 32'h0000_0000);
    rd(8'h18, 32'h0000_0000);
    rd(8'h20, 32'hAB60_0012);

    idle(2);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
